// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer_pkg
// Description : Shared types and constants for the control sequencer:
//               FSM state encoding, opcode values, opcode class decode and
//               the default memory wait limit.
// Revision    : 1.0 - initial release
// ============================================================================
package control_sequencer_pkg;

   // Default number of cycles to wait for mem_ready before declaring a fault
   localparam int c_MEM_TIMEOUT_DEFAULT = 15;

   // Width of the memory wait counter (covers the full 1..255 timeout range)
   localparam int c_WAIT_W = 8;

   // FSM states; encoding is visible on the debug state port
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_t;

   // Opcode values with a dedicated behaviour
   localparam logic [3:0] c_OP_HALT   = 4'h0;
   localparam logic [3:0] c_OP_JUMP   = 4'h5;
   localparam logic [3:0] c_OP_BRANCH = 4'h6;
   localparam logic [3:0] c_OP_LOAD   = 4'h7;
   localparam logic [3:0] c_OP_STORE  = 4'h8;

   // Instruction classes that steer the EXEC/MEM sequencing
   typedef enum logic [2:0] {
      CL_HALT   = 3'd0,
      CL_ALU    = 3'd1,
      CL_JUMP   = 3'd2,
      CL_BRANCH = 3'd3,
      CL_LOAD   = 3'd4,
      CL_STORE  = 3'd5,
      CL_NOP    = 3'd6
   } op_class_t;

   // Map a 4-bit opcode onto its class; 0x1-0x4 are ALU, 0x9-0xF are NOP
   function automatic op_class_t op_class(input logic [3:0] op);
      op_class_t cls;
      case (op)
         c_OP_HALT:                cls = CL_HALT;
         4'h1, 4'h2, 4'h3, 4'h4:   cls = CL_ALU;
         c_OP_JUMP:                cls = CL_JUMP;
         c_OP_BRANCH:              cls = CL_BRANCH;
         c_OP_LOAD:                cls = CL_LOAD;
         c_OP_STORE:               cls = CL_STORE;
         default:                  cls = CL_NOP;
      endcase
      return cls;
   endfunction

endpackage : control_sequencer_pkg
`default_nettype wire

// File: rtl/control_sequencer_wait.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_timer
// Description : Counts memory wait cycles (mem_ready low during an access)
//               and flags the cycle in which the count reaches MEM_TIMEOUT.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_timer
   import control_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = c_MEM_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count,
   output logic expired
);

   // Value held by the counter during the final permitted wait cycle
   localparam logic [c_WAIT_W-1:0] c_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

   logic [c_WAIT_W-1:0] r_cnt;

   // Wait counter: clear has priority so a new access always starts at zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (count) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   // Expires in the wait cycle that brings the total up to MEM_TIMEOUT
   assign expired = count && (r_cnt == c_LAST);

endmodule : mem_wait_timer
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Multi-cycle instruction control FSM. Sequences fetch,
//               decode, execute, memory and write-back, issues the
//               datapath strobes, counts retired instructions and halts
//               with a sticky fault on a memory timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = c_MEM_TIMEOUT_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] op_code,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       ir_we,
   output logic       pc_we,
   output logic       reg_we,
   output logic [2:0] state,
   output logic       halted,
   output logic       fault,
   output logic [7:0] retired
);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_op;
   op_class_t  w_cls;
   logic       w_in_access;
   logic       w_wait_clear;
   logic       w_wait_count;
   logic       w_expired;
   logic [7:0] r_retired;
   logic       r_fault;

   assign w_cls        = op_class(r_op);
   assign w_in_access  = (r_state == ST_FETCH) || (r_state == ST_MEM);
   assign w_wait_count = w_in_access && !mem_ready;
   // Any state change clears the counter, so every FETCH/MEM entry starts fresh
   assign w_wait_clear = (w_next != r_state);

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait (
      .clk     (clk),
      .reset   (reset),
      .clear   (w_wait_clear),
      .count   (w_wait_count),
      .expired (w_expired)
   );

   // Next-state and strobe decode from current state, latched opcode and mem_ready
   always_comb begin
      w_next  = r_state;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      reg_we  = 1'b0;
      halted  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_next = ST_FETCH;
         end
         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we  = 1'b1;
               w_next = ST_DECODE;
            end else if (w_expired) begin
               w_next = ST_HALT;
            end
         end
         ST_DECODE: begin
            w_next = ST_EXEC;
         end
         ST_EXEC: begin
            case (w_cls)
               CL_ALU:             w_next = ST_WB;
               CL_LOAD, CL_STORE:  w_next = ST_MEM;
               CL_HALT:            w_next = ST_HALT;
               default: begin
                  pc_we  = 1'b1;
                  w_next = ST_FETCH;
               end
            endcase
         end
         ST_MEM: begin
            mem_req = 1'b1;
            mem_we  = (w_cls == CL_STORE);
            if (mem_ready) begin
               if (w_cls == CL_STORE) begin
                  pc_we  = 1'b1;
                  w_next = ST_FETCH;
               end else begin
                  w_next = ST_WB;
               end
            end else if (w_expired) begin
               w_next = ST_HALT;
            end
         end
         ST_WB: begin
            reg_we = 1'b1;
            pc_we  = 1'b1;
            w_next = ST_FETCH;
         end
         ST_HALT: begin
            halted = 1'b1;
            if (start) w_next = ST_FETCH;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // State register; opcode is captured only at the end of DECODE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_op    <= 4'h0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_DECODE) r_op <= op_code;
      end
   end

   // Retired-instruction counter, one per PC update, wraps naturally at 8 bits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_retired <= 8'd0;
      end else if (pc_we) begin
         r_retired <= r_retired + 8'd1;
      end
   end

   // Sticky timeout fault, cleared when restarting out of HALT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fault <= 1'b0;
      end else if (w_expired) begin
         r_fault <= 1'b1;
      end else if ((r_state == ST_HALT) && start) begin
         r_fault <= 1'b0;
      end
   end

   assign state   = r_state;
   assign fault   = r_fault;
   assign retired = r_retired;

endmodule : control_sequencer
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed, scoreboard-checked bench for control_sequencer.
//               The stimulus process drives one input vector per cycle and
//               queues the hand-derived output vector for that cycle; a
//               monitor on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   logic       clk       = 1'b0;
   logic       reset     = 1'b1;
   logic       start     = 1'b0;
   logic [3:0] op_code   = 4'h0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_we, ir_we, pc_we, reg_we, halted, fault;
   logic [2:0] state;
   logic [7:0] retired;

   typedef struct {
      string       nm;
      logic [17:0] v;   // {state, mem_req, mem_we, ir_we, pc_we, reg_we, halted, fault, retired}
   } exp_t;

   exp_t        q[$];
   exp_t        m_e;
   logic [17:0] m_got;
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  exp_ret  = 8'd0;
   logic [3:0]  nop_op;

   control_sequencer #(
      .MEM_TIMEOUT (15)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op_code   (op_code),
      .mem_ready (mem_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .ir_we     (ir_we),
      .pc_we     (pc_we),
      .reg_we    (reg_we),
      .state     (state),
      .halted    (halted),
      .fault     (fault),
      .retired   (retired)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   // Queue the expected outputs; the retired model advances after any pc_we cycle
   task automatic push(input string nm, input logic [2:0] st,
                       input logic mreq, input logic mwe, input logic irwe,
                       input logic pcwe, input logic regwe, input logic hlt,
                       input logic flt);
      exp_t e;
      e.nm = nm;
      e.v  = {st, mreq, mwe, irwe, pcwe, regwe, hlt, flt, exp_ret};
      q.push_back(e);
      if (pcwe) exp_ret = exp_ret + 8'd1;
   endtask

   // One clock cycle: drive inputs just after the edge, queue expected outputs
   task automatic cyc(input logic s, input logic [3:0] op, input logic rdy,
                      input string nm, input logic [2:0] st,
                      input logic mreq, input logic mwe, input logic irwe,
                      input logic pcwe, input logic regwe, input logic hlt,
                      input logic flt);
      @(posedge clk);
      #1;
      start     = s;
      op_code   = op;
      mem_ready = rdy;
      push(nm, st, mreq, mwe, irwe, pcwe, regwe, hlt, flt);
   endtask

   // Monitor: compare the DUT outputs against the oldest queued expectation
   always @(negedge clk) begin
      if (q.size() > 0) begin
         m_e   = q.pop_front();
         m_got = {state, mem_req, mem_we, ir_we, pc_we, reg_we, halted, fault, retired};
         n_checks++;
         if (m_got !== m_e.v) begin
            n_fail++;
            $display("FAIL %s @%0t: got state=%0d req=%b we=%b ir=%b pc=%b rg=%b hlt=%b flt=%b ret=%0d ; expected state=%0d req=%b we=%b ir=%b pc=%b rg=%b hlt=%b flt=%b ret=%0d",
                     m_e.nm, $time,
                     m_got[17:15], m_got[14], m_got[13], m_got[12], m_got[11], m_got[10], m_got[9], m_got[8], m_got[7:0],
                     m_e.v[17:15], m_e.v[14], m_e.v[13], m_e.v[12], m_e.v[11], m_e.v[10], m_e.v[9], m_e.v[8], m_e.v[7:0]);
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, queue depth %0d, required 0", q.size());
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus
   initial begin
      // Reset held: everything zero
      cyc(0, 4'h0, 0, "rst_hold", S_IDLE, 0,0,0,0,0,0,0);
      @(negedge clk); #1; reset = 1'b0;

      // JUMP, zero wait: states 1,2,3,1 and one pc_we in EXEC
      cyc(0, 4'h0, 0, "idle_wait",  S_IDLE,   0,0,0,0,0,0,0);
      cyc(1, 4'h5, 1, "idle_start", S_IDLE,   0,0,0,0,0,0,0);
      cyc(0, 4'h5, 1, "j_fetch",    S_FETCH,  1,0,1,0,0,0,0);
      cyc(0, 4'h5, 1, "j_decode",   S_DECODE, 0,0,0,0,0,0,0);
      cyc(0, 4'h0, 1, "j_exec",     S_EXEC,   0,0,0,1,0,0,0);

      // LOAD with two wait cycles in FETCH and in MEM: 9 cycles total
      cyc(0, 4'h0, 0, "l_fetch_w0",  S_FETCH,  1,0,0,0,0,0,0);
      cyc(0, 4'h0, 0, "l_fetch_w1",  S_FETCH,  1,0,0,0,0,0,0);
      cyc(0, 4'h7, 1, "l_fetch_rdy", S_FETCH,  1,0,1,0,0,0,0);
      cyc(0, 4'h7, 1, "l_decode",    S_DECODE, 0,0,0,0,0,0,0);
      cyc(0, 4'h8, 0, "l_exec",      S_EXEC,   0,0,0,0,0,0,0);
      cyc(0, 4'h8, 0, "l_mem_w0",    S_MEM,    1,0,0,0,0,0,0);
      cyc(0, 4'h8, 0, "l_mem_w1",    S_MEM,    1,0,0,0,0,0,0);
      cyc(0, 4'h8, 1, "l_mem_rdy",   S_MEM,    1,0,0,0,0,0,0);
      cyc(0, 4'h8, 0, "l_wb",        S_WB,     0,0,0,1,1,0,0);

      // STORE, zero wait: write access in MEM retires directly
      cyc(0, 4'h8, 1, "s_fetch",  S_FETCH,  1,0,1,0,0,0,0);
      cyc(0, 4'h8, 1, "s_decode", S_DECODE, 0,0,0,0,0,0,0);
      cyc(0, 4'h0, 0, "s_exec",   S_EXEC,   0,0,0,0,0,0,0);
      cyc(0, 4'h0, 1, "s_mem",    S_MEM,    1,1,0,1,0,0,0);

      // ALU, zero wait
      cyc(0, 4'h3, 1, "a_fetch",  S_FETCH,  1,0,1,0,0,0,0);
      cyc(0, 4'h3, 1, "a_decode", S_DECODE, 0,0,0,0,0,0,0);
      cyc(0, 4'h0, 0, "a_exec",   S_EXEC,   0,0,0,0,0,0,0);
      cyc(0, 4'h0, 0, "a_wb",     S_WB,     0,0,0,1,1,0,0);

      // Counter restarts on MEM entry: 10 FETCH waits then 14 MEM waits, no timeout
      for (int i = 0; i < 10; i++)
         cyc(0, 4'h0, 0, "c_fetch_w", S_FETCH, 1,0,0,0,0,0,0);
      cyc(0, 4'h7, 1, "c_fetch_rdy", S_FETCH,  1,0,1,0,0,0,0);
      cyc(0, 4'h7, 0, "c_decode",    S_DECODE, 0,0,0,0,0,0,0);
      cyc(0, 4'h0, 0, "c_exec",      S_EXEC,   0,0,0,0,0,0,0);
      for (int i = 0; i < 14; i++)
         cyc(0, 4'h0, 0, "c_mem_w", S_MEM, 1,0,0,0,0,0,0);
      cyc(0, 4'h0, 1, "c_mem_rdy", S_MEM, 1,0,0,0,0,0,0);
      cyc(0, 4'h0, 0, "c_wb",      S_WB,  0,0,0,1,1,0,0);

      // STORE that times out in MEM after 15 waits
      cyc(0, 4'h8, 1, "so_fetch",  S_FETCH,  1,0,1,0,0,0,0);
      cyc(0, 4'h8, 0, "so_decode", S_DECODE, 0,0,0,0,0,0,0);
      cyc(0, 4'h0, 0, "so_exec",   S_EXEC,   0,0,0,0,0,0,0);
      for (int i = 0; i < 15; i++)
         cyc(0, 4'h0, 0, "so_mem_w", S_MEM, 1,1,0,0,0,0,0);
      cyc(0, 4'h0, 1, "so_halt",       S_HALT, 0,0,0,0,0,1,1);
      cyc(1, 4'h0, 0, "so_halt_start", S_HALT, 0,0,0,0,0,1,1);

      // FETCH timeout after 15 waits; restart clears the fault
      for (int i = 0; i < 15; i++)
         cyc(0, 4'h0, 0, "fo_fetch_w", S_FETCH, 1,0,0,0,0,0,0);
      cyc(0, 4'h0, 1, "fo_halt",       S_HALT, 0,0,0,0,0,1,1);
      cyc(1, 4'h0, 0, "fo_halt_start", S_HALT, 0,0,0,0,0,1,1);

      // 256 NOPs: retired passes 255 -> 0 and returns to its starting value
      for (int i = 0; i < 256; i++) begin
         nop_op = 4'(9 + (i % 7));
         cyc(0, nop_op, 1, "nop_fetch",  S_FETCH,  1,0,1,0,0,0,0);
         cyc(0, nop_op, 1, "nop_decode", S_DECODE, 0,0,0,0,0,0,0);
         cyc(0, nop_op, 1, "nop_exec",   S_EXEC,   0,0,0,1,0,0,0);
      end

      // HALT opcode: no pc_we, retired unchanged, fault stays clear
      cyc(0, 4'h0, 1, "h_fetch",      S_FETCH,  1,0,1,0,0,0,0);
      cyc(0, 4'h0, 1, "h_decode",     S_DECODE, 0,0,0,0,0,0,0);
      cyc(0, 4'h0, 1, "h_exec",       S_EXEC,   0,0,0,0,0,0,0);
      cyc(0, 4'h0, 0, "h_halt",       S_HALT,   0,0,0,0,0,1,0);
      cyc(1, 4'h0, 0, "h_halt_start", S_HALT,   0,0,0,0,0,1,0);

      // Reset asserted mid-MEM: outputs drop without a clock edge
      cyc(0, 4'h7, 1, "r_fetch",  S_FETCH,  1,0,1,0,0,0,0);
      cyc(0, 4'h7, 0, "r_decode", S_DECODE, 0,0,0,0,0,0,0);
      cyc(0, 4'h0, 0, "r_exec",   S_EXEC,   0,0,0,0,0,0,0);
      cyc(0, 4'h0, 0, "r_mem",    S_MEM,    1,0,0,0,0,0,0);
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      #1;
      reset   = 1'b1;
      exp_ret = 8'd0;
      push("r_async", S_IDLE, 0,0,0,0,0,0,0);
      cyc(1, 4'h0, 1, "r_hold", S_IDLE, 0,0,0,0,0,0,0);
      @(negedge clk); #1; reset = 1'b0; start = 1'b0;

      // After release, stay in IDLE until start is sampled
      cyc(0, 4'h0, 0, "r_idle",       S_IDLE,  0,0,0,0,0,0,0);
      cyc(1, 4'h5, 1, "r_idle_start", S_IDLE,  0,0,0,0,0,0,0);
      cyc(0, 4'h5, 1, "r_fetch2",     S_FETCH, 1,0,1,0,0,0,0);

      // Drain: every queued expectation must have been consumed
      repeat (2) @(posedge clk);
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_control_sequencer
`default_nettype wire

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning max wait cycles for mem_ready before fault (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single system clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-004 SHALL have port start  input  1  level; leaves IDLE/HALT and begins fetch.
REQ-005 SHALL have port op_code  input  4  opcode field of instruction register.
REQ-006 SHALL have port mem_ready  input  1  memory completes current request this cycle.
REQ-007 SHALL have port mem_req  output  1  memory access request, held until mem_ready.
REQ-008 SHALL have port mem_we  output  1  write qualifier for mem_req (STORE only).
REQ-009 SHALL have port ir_we  output  1  instruction-register load strobe.
REQ-010 SHALL have port pc_we  output  1  PC update strobe (loads PC_next).
REQ-011 SHALL have port reg_we  output  1  register-file write strobe.
REQ-012 SHALL have port state  output  3  current state encoding, for debug.
REQ-013 SHALL have port halted  output  1  high while in HALT.
REQ-014 SHALL have port fault  output  1  sticky memory-timeout flag.
REQ-015 SHALL have port retired  output  8  retired-instruction count.

Function
REQ-016 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; state registered, outputs decoded combinationally from state, op_q and mem_ready.
REQ-017 Opcode classes: 0000 HALT; 0001-0100 ALU; 0101 JUMP; 0110 BRANCH; 0111 LOAD; 1000 STORE; 1001-1111 NOP.
REQ-018 IDLE: all strobes 0; start=1 -> FETCH next cycle.
REQ-019 FETCH: mem_req=1, mem_we=0; ir_we=mem_ready; on mem_ready -> DECODE.
REQ-020 DECODE: one cycle; op_code latched into op_q; -> EXEC; later op_code changes are ignored.
REQ-021 EXEC: ALU -> WB; LOAD/STORE -> MEM; JUMP/BRANCH/NOP: pc_we=1, -> FETCH; HALT: pc_we=0, -> HALT.
REQ-022 MEM: mem_req=1, mem_we=(op_q==STORE); on mem_ready: LOAD -> WB, STORE pc_we=1 -> FETCH.
REQ-023 WB: reg_we=1, pc_we=1, -> FETCH.
REQ-024 HALT: halted=1, strobes 0; start=1 -> FETCH, clears fault; PC not advanced.
REQ-025 Wait counter clears on entry to FETCH/MEM and counts each cycle mem_ready=0; reaching MEM_TIMEOUT -> HALT, fault=1, no strobe issued.
REQ-026 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-027 retired SHALL increment by 1 on every pc_we=1 cycle, 8-bit wrap 255->0; HALT opcode does not increment.
REQ-028 Zero-wait latency (mem_ready=1 same cycle as mem_req): JUMP/BRANCH/NOP 3 cycles, ALU/STORE 4, LOAD 5, FETCH entry to next FETCH entry.
REQ-029 At most one of ir_we, pc_we per cycle except WB (pc_we+reg_we); mem_we=1 only with mem_req=1.

Reset
REQ-030 reset=1 SHALL asynchronously force state=IDLE, op_q=0, wait counter=0, retired=0, fault=0.
REQ-031 During reset all outputs SHALL be 0 except state=0; reset mid-access drops mem_req immediately, no strobes.
REQ-032 After reset release, SHALL remain in IDLE until start=1 sampled on a clk edge.

Structure
REQ-033 Shared package SHALL hold state enum, opcode constants/class decode function, MEM_TIMEOUT default.
REQ-034 Wait counter SHALL be one sub-module mem_wait_timer (clear, count, expired); remainder in control_sequencer.

Verification
REQ-035 Reset, start=1, op=0101, mem_ready=1 constantly -> states 1,2,3,1; pc_we one cycle in EXEC; retired=1.
REQ-036 op=0111, mem_ready delayed 2 cycles in FETCH and MEM -> mem_req held 3 cycles each, mem_we=0, reg_we+pc_we in WB, 9 cycles total.
REQ-037 op=1000 zero-wait -> mem_req=mem_we=1 in MEM, pc_we there, reg_we never asserted, 4 cycles.
REQ-038 mem_ready=0 in FETCH for 15 cycles -> HALT, fault=1, halted=1, pc_we never; start=1 -> FETCH, fault=0.
REQ-039 Run 256 NOP instructions -> retired wraps 255->0; op=0000 then -> HALT, retired unchanged.
REQ-040 reset asserted mid-MEM with mem_req=1 -> same-cycle mem_req=0, state=0, retired=0, no strobe.
